window_gen_3x3: RTL and testbench

Streaming 3x3 sliding-window generator that feeds the convolution MAC. It accepts a raster-order 8-bit unsigned pixel stream and buffers the two previous image rows in internal line buffers. For every pixel that completes a full in-image 3x3 neighbourhood, it presents the nine window pixels with a one-cycle valid strobe. The outputs connect directly to the MAC window inputs (w00..w22) and its pixel-valid input. Border handling is valid-only, with no padding: an IMG_W x IMG_H frame yields (IMG_W-2) x (IMG_H-2) windows.

---
 rtl/window_gen_3x3_if.sv | 22 ++
 rtl/window_gen_3x3.sv | 101 ++++++++++
 tb/tb_window_gen_3x3.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/window_gen_3x3_if.sv
// Pixel-stream / 3x3-window bundle between the pixel source and the window generator.
// The master side drives the pixel stream; the slave side produces the window and strobes.
interface window_gen_3x3_if;
    logic [7:0] pix_in;
    logic       pix_in_valid;
    logic       sof;
    logic [7:0] w00, w01, w02;
    logic [7:0] w10, w11, w12;
    logic [7:0] w20, w21, w22;
    logic       win_valid;
    logic       frame_done;

    modport master (
        output pix_in, pix_in_valid, sof,
        input  w00, w01, w02, w10, w11, w12, w20, w21, w22, win_valid, frame_done
    );

    modport slave (
        input  pix_in, pix_in_valid, sof,
        output w00, w01, w02, w10, w11, w12, w20, w21, w22, win_valid, frame_done
    );
endinterface

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 sliding-window generator: two line buffers plus a 3x3 shift window.
// A window is flagged valid only when all nine taps come from the current frame (no padding).
module window_gen_3x3 #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    window_gen_3x3_if.slave   s
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col_reg, col_next, c_cur;
    logic [RW-1:0] row_reg, row_next, r_cur;
    logic          win_valid_reg, win_valid_next;
    logic          frame_done_reg, frame_done_next;
    logic [7:0]    lb_a [IMG_W];
    logic [7:0]    lb_b [IMG_W];
    logic [7:0]    new_col [3];
    logic [23:0]   win_rows [3];

    // sof overrides the counters so the accepted pixel lands at (0,0)
    assign c_cur = s.sof ? '0 : col_reg;
    assign r_cur = s.sof ? '0 : row_reg;

    assign new_col[0] = lb_a[c_cur];
    assign new_col[1] = lb_b[c_cur];
    assign new_col[2] = s.pix_in;

    always_comb begin
        col_next        = col_reg;
        row_next        = row_reg;
        win_valid_next  = 1'b0;
        frame_done_next = 1'b0;
        if (s.pix_in_valid) begin
            if (c_cur == CW'(IMG_W - 1)) begin
                col_next = '0;
                row_next = (r_cur == RW'(IMG_H - 1)) ? '0 : r_cur + RW'(1);
            end else begin
                col_next = c_cur + CW'(1);
                row_next = r_cur;
            end
            win_valid_next  = (r_cur >= RW'(2)) && (c_cur >= CW'(2));
            frame_done_next = (r_cur == RW'(IMG_H - 1)) && (c_cur == CW'(IMG_W - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg        <= '0;
            row_reg        <= '0;
            win_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            col_reg        <= col_next;
            row_reg        <= row_next;
            win_valid_reg  <= win_valid_next;
            frame_done_reg <= frame_done_next;
        end
    end

    // Line buffers are deliberately not reset; stale contents never reach a valid window.
    always_ff @(posedge clk) begin
        if (s.pix_in_valid) begin
            lb_a[c_cur] <= lb_b[c_cur];
            lb_b[c_cur] <= s.pix_in;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : row_g
            logic [7:0] tap_reg [3];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tap_reg[0] <= '0;
                    tap_reg[1] <= '0;
                    tap_reg[2] <= '0;
                end else if (s.pix_in_valid) begin
                    tap_reg[0] <= tap_reg[1];
                    tap_reg[1] <= tap_reg[2];
                    tap_reg[2] <= new_col[gi];
                end
            end
            assign win_rows[gi] = {tap_reg[0], tap_reg[1], tap_reg[2]};
        end
    endgenerate

    assign s.w00 = win_rows[0][23:16];
    assign s.w01 = win_rows[0][15:8];
    assign s.w02 = win_rows[0][7:0];
    assign s.w10 = win_rows[1][23:16];
    assign s.w11 = win_rows[1][15:8];
    assign s.w12 = win_rows[1][7:0];
    assign s.w20 = win_rows[2][23:16];
    assign s.w21 = win_rows[2][15:8];
    assign s.w22 = win_rows[2][7:0];

    assign s.win_valid  = win_valid_reg;
    assign s.frame_done = frame_done_reg;
endmodule

// File: tb/tb_window_gen_3x3.sv
// Randomised self-checking bench for window_gen_3x3 on a 5x5 image.
// A frame-image model derives each expected window from pixel positions.
module tb_window_gen_3x3;
    localparam int W = 5;
    localparam int H = 5;

    logic clk;
    logic rst_n;
    window_gen_3x3_if bus ();

    window_gen_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: image of the current frame indexed by position, plus the position counter.
    int          img [H][W];
    int          pos_r = 0;
    int          pos_c = 0;
    logic        exp_valid;
    logic        exp_fd;
    logic [71:0] exp_win;

    // Recorded observations
    int          win_count = 0;
    int          fd_count  = 0;
    logic [71:0] wq [$];
    logic [71:0] fd_win;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] dut_win();
        return {bus.w00, bus.w01, bus.w02, bus.w10, bus.w11, bus.w12, bus.w20, bus.w21, bus.w22};
    endfunction

    task automatic model_reset();
        pos_r = 0;
        pos_c = 0;
    endtask

    task automatic cycle(input logic [7:0] p, input logic v, input logic sf);
        int r;
        int c;
        bus.pix_in       = p;
        bus.pix_in_valid = v;
        bus.sof          = sf;
        exp_valid = 1'b0;
        exp_fd    = 1'b0;
        if (v) begin
            r = sf ? 0 : pos_r;
            c = sf ? 0 : pos_c;
            img[r][c] = p;
            exp_valid = (r >= 2) && (c >= 2);
            exp_fd    = (r == H - 1) && (c == W - 1);
            if (exp_valid) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp_win[71 - 8 * (3 * i + j) -: 8] = 8'(img[r - 2 + i][c - 2 + j]);
            end
            if (c == W - 1) begin
                pos_c = 0;
                pos_r = (r == H - 1) ? 0 : r + 1;
            end else begin
                pos_c = c + 1;
                pos_r = r;
            end
        end
        @(posedge clk);
        #1;
        chk("win_valid", 72'(bus.win_valid), 72'(exp_valid));
        chk("frame_done", 72'(bus.frame_done), 72'(exp_fd));
        if (exp_valid) chk("window", dut_win(), exp_win);
        if (bus.win_valid) begin
            win_count++;
            wq.push_back(dut_win());
        end
        if (bus.frame_done) begin
            fd_count++;
            fd_win = dut_win();
        end
        $display("cycle v=%0b sof=%0b pix=%0d -> win_valid=%0b frame_done=%0b w=%h",
                 v, sf, p, bus.win_valid, bus.frame_done, dut_win());
    endtask

    // mode 0: ramp base+5r+c+1, mode 1: 0/255 checkerboard. duty = percent valid.
    task automatic send_frame(input int base, input int mode, input int duty, input bit first_sof);
        logic [7:0] p;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                while ($urandom_range(99) >= 32'(duty))
                    cycle(8'($urandom), 1'b0, 1'($urandom));
                p = (mode == 0) ? 8'(base + 5 * r + c + 1) : (((r + c) % 2 == 1) ? 8'd255 : 8'd0);
                cycle(p, 1'b1, first_sof && r == 0 && c == 0);
            end
        end
    endtask

    task automatic clear_stats();
        win_count = 0;
        fd_count  = 0;
        wq.delete();
        fd_win = '0;
    endtask

    initial begin
        rst_n = 1'b1;
        bus.pix_in = '0;
        bus.pix_in_valid = 1'b0;
        bus.sof = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset win_valid", 72'(bus.win_valid), 72'd0);
        chk("reset frame_done", 72'(bus.frame_done), 72'd0);
        chk("reset window", dut_win(), 72'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Ramp, continuous valid
        clear_stats();
        send_frame(0, 0, 100, 1'b1);
        chk("ramp count", 72'(win_count), 72'd9);
        chk("ramp first", wq[0], {8'd1, 8'd2, 8'd3, 8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13});
        chk("ramp last", wq[wq.size() - 1], {8'd13, 8'd14, 8'd15, 8'd18, 8'd19, 8'd20, 8'd23, 8'd24, 8'd25});
        chk("ramp fd count", 72'(fd_count), 72'd1);
        chk("ramp fd window", fd_win, {8'd13, 8'd14, 8'd15, 8'd18, 8'd19, 8'd20, 8'd23, 8'd24, 8'd25});
        cycle(8'd0, 1'b0, 1'b0);

        // Ramp with ~50% valid duty
        clear_stats();
        send_frame(0, 0, 50, 1'b0);
        chk("gappy count", 72'(win_count), 72'd9);
        chk("gappy first", wq[0], {8'd1, 8'd2, 8'd3, 8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13});
        cycle(8'd0, 1'b0, 1'b0);

        // Back-to-back frames, second offset by 100
        clear_stats();
        send_frame(0, 0, 100, 1'b1);
        send_frame(100, 0, 100, 1'b1);
        chk("b2b count", 72'(win_count), 72'd18);
        chk("b2b frame2 first", wq[9], {8'd101, 8'd102, 8'd103, 8'd106, 8'd107, 8'd108, 8'd111, 8'd112, 8'd113});
        chk("b2b fd count", 72'(fd_count), 72'd2);

        // Async reset mid-row 3
        for (int k = 0; k < 5 * 3 + 3; k++) cycle(8'(k + 1), 1'b1, 1'b0);
        #3 rst_n = 1'b0;
        bus.pix_in_valid = 1'b0;
        #1;
        chk("midreset win_valid", 72'(bus.win_valid), 72'd0);
        chk("midreset window", dut_win(), 72'd0);
        model_reset();
        #2 rst_n = 1'b1;
        clear_stats();
        send_frame(0, 0, 100, 1'b0);
        chk("post-reset count", 72'(win_count), 72'd9);
        chk("post-reset first", wq[0], {8'd1, 8'd2, 8'd3, 8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13});

        // sof resync on the 8th pixel of a frame
        clear_stats();
        for (int k = 0; k < 7; k++) cycle(8'(200 + k), 1'b1, 1'b0);
        send_frame(50, 0, 70, 1'b1);
        chk("resync count", 72'(win_count), 72'd9);
        chk("resync fd count", 72'(fd_count), 72'd1);
        chk("resync first", wq[0], {8'd51, 8'd52, 8'd53, 8'd56, 8'd57, 8'd58, 8'd61, 8'd62, 8'd63});

        // 0/255 checkerboard
        clear_stats();
        send_frame(0, 1, 60, 1'b1);
        chk("checker count", 72'(win_count), 72'd9);
        chk("checker first", wq[0], {8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0});
        chk("checker second", wq[1], {8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
